snn_dma_master: RTL and testbench

//  Wishbone initiator side of the accelerator's dma_* port. Single-channel DMA engine:
//  MEM->FIFO reads spike words from system memory into the input spike FIFO;

---
 rtl/snn_dma_pkg.sv | 29 ++
 rtl/snn_dma_master.sv | 197 +++++++++++++++++++
 tb/tb_snn_dma_master.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_dma_pkg.sv
// Shared types and constants for the snn_dma_master Wishbone DMA initiator.
package snn_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BUS,
    S_WR_FETCH,
    S_WR_BUS,
    S_FINISH
  } dma_state_e;

  localparam logic        DIR_MEM2FIFO = 1'b0;
  localparam logic        DIR_FIFO2MEM = 1'b1;
  localparam int unsigned ADDR_STRIDE  = 4;

  // First working state of a non-empty transfer for the requested direction.
  function automatic dma_state_e first_state(input logic dir);
    dma_state_e s;
    s = S_RD_WAIT;
    case (dir)
      DIR_MEM2FIFO: s = S_RD_WAIT;
      DIR_FIFO2MEM: s = S_WR_FETCH;
      default:      s = S_RD_WAIT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/snn_dma_master.sv
// snn_dma_master: single-channel Wishbone DMA initiator between system memory
// and the accelerator spike FIFOs (MEM->FIFO reads, FIFO->MEM writes).
// Optional feature macro: DMA_TIMEOUT_EN (per-beat ack timeout, sticky err).
module snn_dma_master
  import snn_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [ADDR_WIDTH-1:0] dma_adr_o,
  output logic [DATA_WIDTH-1:0] dma_dat_o,
  input  logic [DATA_WIDTH-1:0] dma_dat_i,
  output logic                  dma_we_o,
  output logic                  dma_stb_o,
  output logic                  dma_cyc_o,
  input  logic                  dma_ack_i,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty
);

  // A zero timeout would end every beat before the target could answer.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("snn_dma_master: TIMEOUT_CYCLES must be at least 1");
  end

  dma_state_e            state_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  words_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] dat_o_q;
  logic                  fifo_wr_en_q;
  logic [DATA_WIDTH-1:0] fifo_wr_data_q;
  logic                  fifo_rd_en_q;

  logic [LEN_WIDTH-1:0]  words_inc;
  logic                  last_beat;

  assign words_inc = words_q + LEN_WIDTH'(1);
  // The beat being acknowledged is the final one, or abort cuts the transfer short.
  assign last_beat = (words_inc == len_q) || abort;

`ifdef DMA_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_hit;
  // Last cycle of the allowed wait window for the current beat.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

  // Transfer FSM: sequences Wishbone beats and FIFO handshakes; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchronous reset clears every register, including data paths, so
      // the bus and FIFO outputs read 0 right after reset rather than stale data.
      state_q        <= S_IDLE;
      adr_q          <= '0;
      len_q          <= '0;
      words_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cyc_q          <= 1'b0;
      we_q           <= 1'b0;
      dat_o_q        <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      fifo_rd_en_q   <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      tmo_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle; states below raise them for
      // exactly one cycle. Non-blocking assignment keeps every register update
      // on the same edge regardless of statement order.
      done_q       <= 1'b0;
      fifo_wr_en_q <= 1'b0;
      fifo_rd_en_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            adr_q   <= base_addr & ~ADDR_WIDTH'(3);
            len_q   <= xfer_len;
            words_q <= '0;
            busy_q  <= 1'b1;
`ifdef DMA_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= (xfer_len == '0) ? S_FINISH : first_state(dir);
          end
        end

        S_RD_WAIT: begin
          if (abort) begin
            state_q <= S_FINISH;
          end else if (!fifo_full) begin
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            tmo_q   <= '0;
`endif
            state_q <= S_RD_BUS;
          end
        end

        S_WR_FETCH: begin
          if (abort) begin
            state_q <= S_FINISH;
          end else if (!fifo_empty) begin
            dat_o_q      <= fifo_rd_data;
            fifo_rd_en_q <= 1'b1;
            cyc_q        <= 1'b1;
            we_q         <= 1'b1;
`ifdef DMA_TIMEOUT_EN
            tmo_q        <= '0;
`endif
            state_q      <= S_WR_BUS;
          end
        end

        S_RD_BUS, S_WR_BUS: begin
          if (dma_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= adr_q + ADDR_WIDTH'(ADDR_STRIDE);
            words_q <= words_inc;
            if (state_q == S_RD_BUS) begin
              fifo_wr_en_q   <= 1'b1;
              fifo_wr_data_q <= dma_dat_i;
            end
            if (last_beat) begin
              state_q <= S_FINISH;
            end else begin
              state_q <= (state_q == S_WR_BUS) ? S_WR_FETCH : S_RD_WAIT;
            end
          end
`ifdef DMA_TIMEOUT_EN
          else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            tmo_q   <= tmo_q + TMO_W'(1);
          end
`endif
        end

        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign words_done   = words_q;
  assign dma_adr_o    = adr_q;
  assign dma_dat_o    = dat_o_q;
  assign dma_we_o     = we_q;
  assign dma_stb_o    = cyc_q;
  assign dma_cyc_o    = cyc_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign fifo_rd_en   = fifo_rd_en_q;

endmodule

// File: tb/tb_snn_dma_master.sv
// Directed scoreboard bench for snn_dma_master: Wishbone slave model with
// configurable wait states, input/output spike FIFO models, bus-protocol monitor.
module tb_snn_dma_master;

  logic        clk = 1'b0;
  logic        rst, start, dir, abort;
  logic [31:0] base_addr;
  logic [15:0] xfer_len;
  logic        busy, done, err;
  logic [15:0] words_done;
  logic [31:0] dma_adr_o, dma_dat_o, dma_dat_i;
  logic        dma_we_o, dma_stb_o, dma_cyc_o, dma_ack_i;
  logic        fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
  logic [31:0] fifo_wr_data, fifo_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snn_dma_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .base_addr(base_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o), .dma_dat_i(dma_dat_i),
    .dma_we_o(dma_we_o), .dma_stb_o(dma_stb_o), .dma_cyc_o(dma_cyc_o),
    .dma_ack_i(dma_ack_i),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by reads: address-dependent so misordered beats show up.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign dma_dat_i = mem_word(dma_adr_o);

  // Wishbone slave: registered ack after slave_waits extra cycles; can go silent.
  int unsigned slave_waits = 0;
  bit          slave_dead  = 1'b0;
  int unsigned wcnt;
  always @(posedge clk) begin
    if (rst) begin
      dma_ack_i <= 1'b0;
      wcnt      <= 0;
    end else if (dma_cyc_o && dma_stb_o && !dma_ack_i && !slave_dead) begin
      if (wcnt >= slave_waits) begin
        dma_ack_i <= 1'b1;
        wcnt      <= 0;
      end else begin
        wcnt      <= wcnt + 1;
      end
    end else begin
      dma_ack_i <= 1'b0;
      wcnt      <= 0;
    end
  end

  // Output spike FIFO model (show-ahead), filled by the stimulus process.
  logic [31:0] out_mem [16];
  int out_wr  = 0;
  int out_rd  = 0;
  int pop_cnt = 0;
  assign fifo_empty   = (out_wr == out_rd);
  assign fifo_rd_data = out_mem[out_rd % 16];
  always @(posedge clk) begin
    if (!rst && fifo_rd_en) begin
      out_rd  <= out_rd + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Scoreboard queues and monitor state.
  logic [31:0] exp_rd  [$];
  logic [31:0] exp_adr [$];
  logic [63:0] exp_wr  [$];
  int  push_cnt   = 0;
  int  done_cnt   = 0;
  int  stb_cycles = 0;
  bit  cyc_seen   = 1'b0;
  bit  allow_drop = 1'b0;
  logic        full_s;
  logic        prev_stb = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(posedge clk) full_s <= fifo_full;

  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (dma_stb_o) stb_cycles++;
      if (dma_cyc_o) cyc_seen = 1'b1;
      if (fifo_wr_en) begin
        push_cnt++;
        check("push_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) check("push_data", fifo_wr_data, exp_rd.pop_front());
      end
      if (fifo_rd_en) check("pop_nonempty", fifo_empty, 0);
      if (dma_cyc_o && dma_stb_o && dma_ack_i) begin
        if (dma_we_o) begin
          check("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) check("wr_beat", {dma_adr_o, dma_dat_o}, exp_wr.pop_front());
        end else begin
          check("rd_expected", exp_adr.size() > 0, 1);
          if (exp_adr.size() > 0) check("rd_adr", dma_adr_o, exp_adr.pop_front());
        end
      end
      if (dma_stb_o && !prev_stb && !dma_we_o) check("stb_while_full", full_s, 0);
      if (prev_stb && !prev_ack && !allow_drop)
        check("bus_hold", {dma_stb_o, dma_cyc_o, dma_we_o, dma_adr_o, dma_dat_o},
                          {1'b1, 1'b1, prev_we, prev_adr, prev_dat});
      prev_stb = dma_stb_o;
      prev_ack = dma_ack_i;
      prev_we  = dma_we_o;
      prev_adr = dma_adr_o;
      prev_dat = dma_dat_o;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic d, input logic [31:0] b, input logic [15:0] n);
    step();
    dir = d; base_addr = b; xfer_len = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_reads(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(b + 32'(4 * i));
      exp_rd.push_back(mem_word(b + 32'(4 * i)));
    end
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic wait_pushes(input int n, input int budget, output int seen);
    int k = 0;
    seen = 0;
    while (seen < n && k < budget) begin
      @(posedge clk);
      #1;
      if (fifo_wr_en) seen++;
      k++;
    end
  endtask

  initial begin
    int d0, p0, q0, s0, n;
    logic [31:0] wdat;

    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    base_addr = '0; xfer_len = '0; fifo_full = 1'b0;
    repeat (3) step();

    check("rst_outputs",
          {busy, done, err, words_done, dma_cyc_o, dma_stb_o, dma_we_o, fifo_wr_en, fifo_rd_en},
          '0);
    check("rst_bus_data", {dma_adr_o, dma_dat_o, fifo_wr_data}, '0);
    rst = 1'b0;
    step();

    // 1: MEM->FIFO, zero-wait slave.
    slave_waits = 0;
    d0 = done_cnt; p0 = push_cnt;
    expect_reads(32'h0000_1000, 4);
    start_xfer(1'b0, 32'h0000_1000, 16'd4);
    check("t1_busy", busy, 1);
    wait_done("t1", d0, 200);
    repeat (3) step();
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_words_done", words_done, 16'd4);
    check("t1_pushes", push_cnt - p0, 4);
    check("t1_err", err, 0);
    check("t1_sb_empty", exp_rd.size() + exp_adr.size(), 0);
    check("t1_idle", {busy, dma_cyc_o}, 2'b00);

    // 2: FIFO->MEM, slave with 2 wait states.
    slave_waits = 2;
    for (int i = 0; i < 3; i++) begin
      wdat = 32'hA000_000A + 32'(i * 32'h0B00_0001);
      out_mem[out_wr % 16] = wdat;
      out_wr++;
      exp_wr.push_back({32'h0000_2000 + 32'(4 * i), wdat});
    end
    d0 = done_cnt; q0 = pop_cnt;
    start_xfer(1'b1, 32'h0000_2003, 16'd3);
    wait_done("t2", d0, 300);
    repeat (2) step();
    check("t2_pops", pop_cnt - q0, 3);
    check("t2_words_done", words_done, 16'd3);
    check("t2_writes_left", exp_wr.size(), 0);
    check("t2_fifo_drained", fifo_empty, 1);

    // 3: MEM->FIFO with back-pressure after two pushes.
    slave_waits = 0;
    d0 = done_cnt; p0 = push_cnt;
    expect_reads(32'h0000_3000, 8);
    start_xfer(1'b0, 32'h0000_3000, 16'd8);
    wait_pushes(2, 100, n);
    check("t3_first_two", n, 2);
    fifo_full = 1'b1;
    step();
    s0 = push_cnt;
    repeat (19) step();
    check("t3_no_push_full", push_cnt - s0, 0);
    check("t3_no_cyc_full", dma_cyc_o, 0);
    fifo_full = 1'b0;
    wait_done("t3", d0, 300);
    check("t3_pushes", push_cnt - p0, 8);
    check("t3_words_done", words_done, 16'd8);
    check("t3_sb_empty", exp_rd.size(), 0);

    // 4a: zero-length transfer.
    d0 = done_cnt; cyc_seen = 1'b0;
    start_xfer(1'b0, 32'h0000_7000, 16'd0);
    check("t4a_done_early", {done, busy}, 2'b01);
    step();
    check("t4a_done_cycle", {done, busy}, 2'b10);
    step();
    check("t4a_done_pulse", done, 0);
    check("t4a_no_cyc", cyc_seen, 0);
    check("t4a_words", words_done, 16'd0);

    // 4b: abort during a wait-stated read beat.
    slave_waits = 3;
    d0 = done_cnt; p0 = push_cnt;
    expect_reads(32'h0000_4000, 10);
    start_xfer(1'b0, 32'h0000_4000, 16'd10);
    wait_pushes(3, 200, n);
    check("t4b_three_pushes", n, 3);
    n = 0;
    while (!(dma_stb_o && !dma_ack_i) && n < 20) begin
      step();
      n++;
    end
    check("t4b_beat_open", dma_stb_o, 1);
    abort = 1'b1;
    wait_done("t4b", d0, 100);
    abort = 1'b0;
    step();
    check("t4b_words_done", words_done, 16'd4);
    check("t4b_pushes", push_cnt - p0, 4);
    exp_rd.delete();
    exp_adr.delete();

    // 6a: start while busy is ignored (a write would pop the staged word).
    slave_waits = 0;
    out_mem[out_wr % 16] = 32'hDEAD_0001;
    out_wr++;
    d0 = done_cnt; q0 = pop_cnt;
    expect_reads(32'h0000_6000, 3);
    start_xfer(1'b0, 32'h0000_6000, 16'd3);
    repeat (3) step();
    check("t6a_busy", busy, 1);
    start_xfer(1'b1, 32'h0000_9000, 16'd7);
    wait_done("t6a", d0, 200);
    repeat (3) step();
    check("t6a_done_once", done_cnt - d0, 1);
    check("t6a_words_done", words_done, 16'd3);
    check("t6a_no_pop", pop_cnt - q0, 0);
    check("t6a_sb_empty", exp_rd.size(), 0);

`ifdef DMA_TIMEOUT_EN
    // 5: silent slave triggers the beat timeout.
    slave_dead = 1'b1; allow_drop = 1'b1;
    d0 = done_cnt; p0 = push_cnt; s0 = stb_cycles;
    start_xfer(1'b0, 32'h0000_5000, 16'd2);
    wait_done("t5", d0, 200);
    step();
    check("t5_stb_cycles", stb_cycles - s0, 16);
    check("t5_err", err, 1);
    check("t5_words", words_done, 16'd0);
    check("t5_no_push", push_cnt - p0, 0);
    check("t5_cyc_low", dma_cyc_o, 0);
    slave_dead = 1'b0; allow_drop = 1'b0;
    d0 = done_cnt;
    expect_reads(32'h0000_5100, 1);
    start_xfer(1'b0, 32'h0000_5100, 16'd1);
    check("t5_err_cleared", err, 0);
    wait_done("t5b", d0, 100);
    check("t5b_words", words_done, 16'd1);
`endif

    // 6b: reset in the middle of an open bus cycle.
    slave_waits = 3; allow_drop = 1'b1;
    expect_reads(32'h0000_8000, 5);
    start_xfer(1'b0, 32'h0000_8000, 16'd5);
    n = 0;
    while (!dma_cyc_o && n < 20) begin
      step();
      n++;
    end
    check("t6b_cyc_open", dma_cyc_o, 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6b_rst_drop", {dma_cyc_o, dma_stb_o, busy, done}, 4'b0000);
    step();
    rst = 1'b0;
    repeat (4) step();
    check("t6b_no_done", {done_cnt - d0, busy, dma_cyc_o}, '0);
    exp_rd.delete();
    exp_adr.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
